// File: rtl/next_pc_pkg.sv
// next_pc_pkg: shared BHT helpers (counter reset value, PC-to-index slice) and next-PC select encoding.
`default_nettype none

package next_pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ     = 2'd0,
        SEL_PRED    = 2'd1,
        SEL_RECOVER = 2'd2
    } next_pc_sel_e;

    // Weakly-taken starting point: 2^(cnt_bits-1).
    function automatic int unsigned cnt_reset_val(input int cnt_bits);
        return 32'd1 << (cnt_bits - 1);
    endfunction

    // Word-aligned PCs: drop the two byte-offset bits, keep idx_bits above them.
    function automatic int unsigned bht_idx(input logic [63:0] pc, input int idx_bits);
        return 32'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bht_next_pc_if.sv
// bht_next_pc_if: pipeline-side signals of the next-PC unit; the optional statistics
// outputs exist only when BHT_STATS_EN is defined.
`default_nettype none

interface bht_next_pc_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_adder_i;
    logic            branch_id_i;
    logic [XLEN-1:0] pc_id_i;
    logic [XLEN-1:0] jmp_id_i;
    logic            branch_ex_i;
    logic [XLEN-1:0] pc_ex_i;
    logic [XLEN-1:0] jmp_ex_i;
    logic            predict_ex_i;
    logic            taken_ex_i;
    logic [XLEN-1:0] next_pc_o;
    logic            predict_o;
    logic            flush_o;
    logic            mispredict_o;
`ifdef BHT_STATS_EN
    logic [XLEN-1:0] stat_branches_o;
    logic [XLEN-1:0] stat_mispredicts_o;
`endif

    modport master (
`ifdef BHT_STATS_EN
        input  stat_branches_o, stat_mispredicts_o,
`endif
        output pc_adder_i, branch_id_i, pc_id_i, jmp_id_i,
        output branch_ex_i, pc_ex_i, jmp_ex_i, predict_ex_i, taken_ex_i,
        input  next_pc_o, predict_o, flush_o, mispredict_o
    );

    modport slave (
`ifdef BHT_STATS_EN
        output stat_branches_o, stat_mispredicts_o,
`endif
        input  pc_adder_i, branch_id_i, pc_id_i, jmp_id_i,
        input  branch_ex_i, pc_ex_i, jmp_ex_i, predict_ex_i, taken_ex_i,
        output next_pc_o, predict_o, flush_o, mispredict_o
    );
endinterface

`default_nettype wire

// File: rtl/bht_table.sv
// bht_table: array of saturating counters with one combinational read port
// and one saturating read-modify-write update port.
`default_nettype none

module bht_table
    import next_pc_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int CNT_BITS = 2
) (
    input  wire logic                clk_i,
    input  wire logic                rst_n_i,
    input  wire logic [IDX_BITS-1:0] rd_idx,
    output logic                     rd_taken,
    input  wire logic                wr_en,
    input  wire logic [IDX_BITS-1:0] wr_idx,
    input  wire logic                wr_taken
);
    localparam int                  ENTRIES = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] RST_VAL = CNT_BITS'(cnt_reset_val(CNT_BITS));

    logic [CNT_BITS-1:0] cnt [ENTRIES];

    // Read returns the stored (pre-update) value; no write-to-read bypass.
    assign rd_taken = cnt[rd_idx][CNT_BITS-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            if (wr_taken && (cnt[wr_idx] != {CNT_BITS{1'b1}})) begin
                cnt[wr_idx] <= cnt[wr_idx] + 1'b1;
            end else if (!wr_taken && (cnt[wr_idx] != '0)) begin
                cnt[wr_idx] <= cnt[wr_idx] - 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/bht_next_pc.sv
// bht_next_pc: BHT-predicted next-PC select with misprediction flush.
// Define BHT_STATS_EN to add saturating branch / mispredict statistics counters.
`default_nettype none

module bht_next_pc
    import next_pc_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 4,
    parameter int CNT_BITS = 2
) (
    input  wire logic     clk_i,
    input  wire logic     rst_n_i,
    bht_next_pc_if.slave  bus
);
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic                rd_taken;
    logic                predict;
    logic                mispredict;
    logic [XLEN-1:0]     recover_pc;
    next_pc_sel_e        sel;

    assign rd_idx = IDX_BITS'(bht_idx(64'(bus.pc_id_i), IDX_BITS));
    assign wr_idx = IDX_BITS'(bht_idx(64'(bus.pc_ex_i), IDX_BITS));

    bht_table #(
        .IDX_BITS (IDX_BITS),
        .CNT_BITS (CNT_BITS)
    ) u_table (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .rd_idx   (rd_idx),
        .rd_taken (rd_taken),
        .wr_en    (bus.branch_ex_i),
        .wr_idx   (wr_idx),
        .wr_taken (bus.taken_ex_i)
    );

    assign predict    = bus.branch_id_i & rd_taken;
    assign mispredict = bus.branch_ex_i & (bus.predict_ex_i != bus.taken_ex_i);
    assign recover_pc = bus.taken_ex_i ? bus.jmp_ex_i : (bus.pc_ex_i + XLEN'(4));

    // EX recovery outranks the ID prediction: the ID instruction is on the wrong path.
    always_comb begin
        sel = SEL_SEQ;
        if (mispredict) begin
            sel = SEL_RECOVER;
        end else if (predict) begin
            sel = SEL_PRED;
        end
    end

    always_comb begin
        bus.next_pc_o = bus.pc_adder_i;
        case (sel)
            SEL_RECOVER: bus.next_pc_o = recover_pc;
            SEL_PRED:    bus.next_pc_o = bus.jmp_id_i;
            default:     bus.next_pc_o = bus.pc_adder_i;
        endcase
    end

    assign bus.predict_o    = predict;
    assign bus.flush_o      = mispredict;
    assign bus.mispredict_o = mispredict;

`ifdef BHT_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.stat_branches_o    <= '0;
            bus.stat_mispredicts_o <= '0;
        end else begin
            if (bus.branch_ex_i && (bus.stat_branches_o != {XLEN{1'b1}})) begin
                bus.stat_branches_o <= bus.stat_branches_o + 1'b1;
            end
            if (mispredict && (bus.stat_mispredicts_o != {XLEN{1'b1}})) begin
                bus.stat_mispredicts_o <= bus.stat_mispredicts_o + 1'b1;
            end
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_bht_next_pc.sv
// tb_bht_next_pc: directed scenarios plus randomized traffic checked against a
// behavioural BHT model; statistics are checked when BHT_STATS_EN is defined.
`default_nettype none

module tb_bht_next_pc;
    localparam int XLEN     = 32;
    localparam int IDX_BITS = 4;
    localparam int CNT_BITS = 2;
    localparam int ENTRIES  = 16;
    localparam int CMAX     = 3;
    localparam int CRST     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bht_next_pc_if #(.XLEN(XLEN)) bus();

    bht_next_pc #(
        .XLEN     (XLEN),
        .IDX_BITS (IDX_BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int     tests = 0;
    int     fails = 0;
    int     mcnt [ENTRIES];
    longint mbr;
    longint mmis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc / 32'd4) % ENTRIES;
    endfunction

    function automatic logic m_predict();
        return bus.branch_id_i && (mcnt[idx_of(bus.pc_id_i)] >= CRST);
    endfunction

    function automatic logic m_mispredict();
        return bus.branch_ex_i && (bus.predict_ex_i != bus.taken_ex_i);
    endfunction

    function automatic logic [31:0] m_next_pc();
        if (m_mispredict()) return bus.taken_ex_i ? bus.jmp_ex_i : bus.pc_ex_i + 32'd4;
        if (m_predict())    return bus.jmp_id_i;
        return bus.pc_adder_i;
    endfunction

    task automatic model_reset();
        foreach (mcnt[i]) mcnt[i] = CRST;
        mbr  = 0;
        mmis = 0;
    endtask

    // Advance one cycle: the model commits EX outcomes at the rising edge, drivers resume at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && bus.branch_ex_i) begin
            int i;
            i = idx_of(bus.pc_ex_i);
            if (bus.taken_ex_i) mcnt[i] = (mcnt[i] < CMAX) ? mcnt[i] + 1 : CMAX;
            else                mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
            mbr++;
            if (bus.predict_ex_i != bus.taken_ex_i) mmis++;
        end
        @(negedge clk);
    endtask

    task automatic drive_id(input logic b, input logic [31:0] pc, input logic [31:0] jmp);
        bus.branch_id_i = b;
        bus.pc_id_i     = pc;
        bus.jmp_id_i    = jmp;
        bus.pc_adder_i  = pc + 32'd4;
    endtask

    task automatic drive_ex(input logic b, input logic [31:0] pc, input logic [31:0] jmp,
                            input logic pred, input logic taken);
        bus.branch_ex_i  = b;
        bus.pc_ex_i      = pc;
        bus.jmp_ex_i     = jmp;
        bus.predict_ex_i = pred;
        bus.taken_ex_i   = taken;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive_id(1'b1, 32'h40, 32'h80);
        #1;
        tests++; if (bus.predict_o !== 1'b1) begin fails++; $display("FAIL reset_predict: got %0b want 1", bus.predict_o); end
        tests++; if (bus.next_pc_o !== 32'h80) begin fails++; $display("FAIL reset_next_pc: got %h want 00000080", bus.next_pc_o); end
        tests++; if (bus.flush_o !== 1'b0) begin fails++; $display("FAIL reset_flush: got %0b want 0", bus.flush_o); end
        rst_n = 1'b1;
        tick();
        #1;
        tests++; if (bus.predict_o !== 1'b1) begin fails++; $display("FAIL post_reset_predict: got %0b want 1", bus.predict_o); end
    endtask

    task automatic test_mispredict();
        drive_id(1'b0, 32'h100, 32'h0);
        drive_ex(1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
        #1;
        tests++; if (bus.flush_o !== 1'b1) begin fails++; $display("FAIL mis_flush: got %0b want 1", bus.flush_o); end
        tests++; if (bus.mispredict_o !== 1'b1) begin fails++; $display("FAIL mis_mispredict: got %0b want 1", bus.mispredict_o); end
        tests++; if (bus.next_pc_o !== 32'h44) begin fails++; $display("FAIL mis_recover_pc: got %h want 00000044", bus.next_pc_o); end
        tick();
        drive_ex(1'b0, 32'h999, 32'h123, 1'b1, 1'b0);
        drive_id(1'b1, 32'h40, 32'h80);
        #1;
        tests++; if (bus.predict_o !== 1'b0) begin fails++; $display("FAIL mis_after_update_predict: got %0b want 0", bus.predict_o); end
        tests++; if (bus.next_pc_o !== 32'h44) begin fails++; $display("FAIL mis_after_update_next_pc: got %h want 00000044", bus.next_pc_o); end
        tests++; if (bus.flush_o !== 1'b0) begin fails++; $display("FAIL bubble_no_flush: got %0b want 0", bus.flush_o); end
        tick();
        drive_id(1'b0, 32'h200, 32'h0);
        drive_ex(1'b1, 32'hFFFF_FFFC, 32'h80, 1'b1, 1'b0);
        #1;
        tests++; if (bus.next_pc_o !== 32'h0) begin fails++; $display("FAIL recover_wrap: got %h want 00000000", bus.next_pc_o); end
        tick();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            drive_id(1'b0, 32'h300, 32'h0);
            drive_ex(1'b1, 32'h10, 32'h500, 1'b1, 1'b1);
            #1;
            tests++; if (bus.flush_o !== 1'b0) begin fails++; $display("FAIL sat_taken_flush[%0d]: got %0b want 0", k, bus.flush_o); end
            tick();
        end
        drive_ex(1'b1, 32'h10, 32'h500, 1'b1, 1'b0);
        #1;
        tests++; if (bus.next_pc_o !== 32'h14) begin fails++; $display("FAIL sat_nt_recover: got %h want 00000014", bus.next_pc_o); end
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive_id(1'b1, 32'h10, 32'h600);
        #1;
        tests++; if (bus.predict_o !== 1'b1) begin fails++; $display("FAIL sat_still_taken: got %0b want 1", bus.predict_o); end
        tests++; if (bus.next_pc_o !== 32'h600) begin fails++; $display("FAIL sat_next_pc: got %h want 00000600", bus.next_pc_o); end
        tick();
    endtask

    task automatic test_priority();
        drive_ex(1'b1, 32'h1F0, 32'h200, 1'b0, 1'b1);
        drive_id(1'b1, 32'h60, 32'h300);
        #1;
        tests++; if (bus.predict_o !== 1'b1) begin fails++; $display("FAIL prio_predict: got %0b want 1", bus.predict_o); end
        tests++; if (bus.next_pc_o !== 32'h200) begin fails++; $display("FAIL prio_recover_wins: got %h want 00000200", bus.next_pc_o); end
        tick();
        drive_ex(1'b1, 32'h1F0, 32'h200, 1'b1, 1'b1);
        drive_id(1'b1, 32'h60, 32'h300);
        #1;
        tests++; if (bus.next_pc_o !== 32'h300) begin fails++; $display("FAIL prio_predicted: got %h want 00000300", bus.next_pc_o); end
        tick();
    endtask

    task automatic test_same_cycle();
        drive_id(1'b0, 32'h400, 32'h0);
        drive_ex(1'b1, 32'h54, 32'h0, 1'b1, 1'b0);
        tick();
        drive_ex(1'b1, 32'h54, 32'h700, 1'b1, 1'b1);
        drive_id(1'b1, 32'h14, 32'h800);
        #1;
        tests++; if (bus.predict_o !== 1'b0) begin fails++; $display("FAIL same_cycle_predict: got %0b want 0", bus.predict_o); end
        tests++; if (bus.flush_o !== 1'b0) begin fails++; $display("FAIL same_cycle_flush: got %0b want 0", bus.flush_o); end
        tests++; if (bus.next_pc_o !== 32'h18) begin fails++; $display("FAIL same_cycle_next_pc: got %h want 00000018", bus.next_pc_o); end
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive_id(1'b1, 32'h14, 32'h800);
        #1;
        tests++; if (bus.predict_o !== 1'b1) begin fails++; $display("FAIL same_cycle_after: got %0b want 1", bus.predict_o); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive_id(1'($urandom_range(0, 1)), $urandom & 32'h0000_00FC, $urandom & 32'hFFFF_FFFC);
            bus.pc_adder_i = $urandom;
            drive_ex(1'($urandom_range(0, 1)), $urandom & 32'h0000_00FC, $urandom & 32'hFFFF_FFFC,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            tests++; if (bus.predict_o !== m_predict()) begin fails++; $display("FAIL rand_predict[%0d]: got %0b want %0b", k, bus.predict_o, m_predict()); end
            tests++; if (bus.flush_o !== m_mispredict()) begin fails++; $display("FAIL rand_flush[%0d]: got %0b want %0b", k, bus.flush_o, m_mispredict()); end
            tests++; if (bus.mispredict_o !== m_mispredict()) begin fails++; $display("FAIL rand_mispredict[%0d]: got %0b want %0b", k, bus.mispredict_o, m_mispredict()); end
            tests++; if (bus.next_pc_o !== m_next_pc()) begin fails++; $display("FAIL rand_next_pc[%0d]: got %h want %h", k, bus.next_pc_o, m_next_pc()); end
`ifdef BHT_STATS_EN
            tests++; if (bus.stat_branches_o !== 32'(mbr)) begin fails++; $display("FAIL rand_stat_br[%0d]: got %0d want %0d", k, bus.stat_branches_o, mbr); end
            tests++; if (bus.stat_mispredicts_o !== 32'(mmis)) begin fails++; $display("FAIL rand_stat_mis[%0d]: got %0d want %0d", k, bus.stat_mispredicts_o, mmis); end
`endif
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive_id(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive_ex(1'b1, 32'h0C, 32'h0, 1'b0, 1'b0);
            tick();
        end
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive_id(1'b1, 32'h0C, 32'h900);
        #1;
        tests++; if (bus.predict_o !== 1'b0) begin fails++; $display("FAIL arst_before: got %0b want 0", bus.predict_o); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (bus.predict_o !== 1'b1) begin fails++; $display("FAIL arst_immediate: got %0b want 1", bus.predict_o); end
`ifdef BHT_STATS_EN
        tests++; if (bus.stat_branches_o !== 32'd0) begin fails++; $display("FAIL arst_stat_br: got %0d want 0", bus.stat_branches_o); end
        tests++; if (bus.stat_mispredicts_o !== 32'd0) begin fails++; $display("FAIL arst_stat_mis: got %0d want 0", bus.stat_mispredicts_o); end
`endif
        drive_ex(1'b1, 32'h0C, 32'h0, 1'b1, 1'b0);
        tick();
        #1;
        tests++; if (bus.flush_o !== 1'b1) begin fails++; $display("FAIL arst_flush_comb: got %0b want 1", bus.flush_o); end
        tests++; if (bus.predict_o !== 1'b1) begin fails++; $display("FAIL arst_no_update: got %0b want 1", bus.predict_o); end
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef BHT_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        drive_id(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            drive_ex(1'b1, $urandom & 32'h0000_00FC, 32'h40, 1'b1, (k < 3) ? 1'b0 : 1'b1);
            tick();
        end
        drive_ex(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        tests++; if (bus.stat_branches_o !== 32'd10) begin fails++; $display("FAIL stats_branches: got %0d want 10", bus.stat_branches_o); end
        tests++; if (bus.stat_mispredicts_o !== 32'd3) begin fails++; $display("FAIL stats_mispredicts: got %0d want 3", bus.stat_mispredicts_o); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (bus.stat_branches_o !== 32'd0) begin fails++; $display("FAIL stats_clear_br: got %0d want 0", bus.stat_branches_o); end
        tests++; if (bus.stat_mispredicts_o !== 32'd0) begin fails++; $display("FAIL stats_clear_mis: got %0d want 0", bus.stat_mispredicts_o); end
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        drive_id(1'b0, 32'h0, 32'h0);
        drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_mispredict();
        test_saturation();
        test_priority();
        test_same_cycle();
        test_random();
        test_async_reset();
`ifdef BHT_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bht_next_pc.md
# bht_next_pc

Next-PC unit with a built-in branch history table (BHT) for the five-stage pipelined CPU. It holds one saturating counter per entry, predicts conditional branches decoded in ID, and checks the prediction when the branch resolves in EX. It selects the next fetch PC from three sources: recovery (EX), predicted target (ID) and sequential (IF). It also raises the pipeline flush on a misprediction.

## Interface
- XLEN, 32, PC / address width
- IDX_BITS, 4, BHT index width; the table has 2^IDX_BITS entries
- CNT_BITS, 2, counter width (≥1)
- clk_i  input  1  clock; all state updates on the rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- pc_adder_i  input  XLEN  PC+4 from IF
- branch_id_i  input  1  ID holds a conditional branch
- pc_id_i  input  XLEN  PC of the ID instruction
- jmp_id_i  input  XLEN  branch target computed in ID
- branch_ex_i  input  1  EX holds a conditional branch (not a bubble)
- pc_ex_i  input  XLEN  PC of the EX branch
- jmp_ex_i  input  XLEN  branch target of the EX branch
- predict_ex_i  input  1  prediction made for the EX branch (the predict_o value carried down the pipeline)
- taken_ex_i  input  1  actual outcome of the EX branch
- next_pc_o  output  XLEN  PC to load into the PC register
- predict_o  output  1  prediction for the ID branch; 0 when branch_id_i=0
- flush_o  output  1  flush IF/ID and ID/EX (misprediction)
- mispredict_o  output  1  same as flush_o; kept separate for the hazard unit and debug

## Operation
- Index: idx(pc) = pc[IDX_BITS+1:2].
- Prediction: predict_o = branch_id_i & cnt[idx(pc_id_i)][CNT_BITS-1].
- Misprediction: mispredict = branch_ex_i & (predict_ex_i != taken_ex_i).
- flush_o and mispredict_o both equal mispredict.
- Recovery PC: jmp_ex_i when taken_ex_i=1, otherwise pc_ex_i+4 (modulo 2^XLEN).
- next_pc_o priority:
  1. mispredict → recovery PC
  2. predict_o → jmp_id_i
  3. otherwise → pc_adder_i
- Counter update, on any cycle with branch_ex_i=1, at cnt[idx(pc_ex_i)]:
  - taken_ex_i=1: increment, saturating at 2^CNT_BITS-1.
  - taken_ex_i=0: decrement, saturating at 0.
- Reset value of every counter: 2^(CNT_BITS-1) (weakly taken; 2'b10 for the default width).
- Same-cycle read and write of the same index: predict_o uses the pre-update value. There is no bypass.
- Aliasing: distinct PCs that share an index share a counter. This is intentional and needs no detection.

## Timing
- next_pc_o, predict_o, flush_o and mispredict_o are combinational from their inputs. There is no added latency.
- Counter writes take effect at the next rising edge and are visible to a prediction one cycle later.
- Reset asserted (asynchronous, including mid-operation):
  - all counters return to their reset value immediately.
  - outputs follow their inputs combinationally with reset counter values, e.g. predict_o = branch_id_i.
  - no update occurs while rst_n_i=0.
- branch_ex_i=0: no table write, and mispredict=0 regardless of the other EX inputs.

## Configuration
- BHT_STATS_EN defined: adds two XLEN-bit registered outputs.
  - stat_branches_o: counts cycles with branch_ex_i=1.
  - stat_mispredicts_o: counts mispredictions.
  - Both counters saturate at all-ones, reset to 0, and update on the same edge as the counters.
- BHT_STATS_EN undefined: these ports and their logic are absent.

## Structure
- Shared package/header `next_pc_pkg` holds:
  - the counter reset function 2^(CNT_BITS-1).
  - the idx(pc) slicing macro/function, reused by the ID/EX pipeline register.
  - the next-PC select encoding: SEL_SEQ=0, SEL_PRED=1, SEL_RECOVER=2.
- Sub-module `bht_table` contains:
  - the counter array.
  - one combinational read port.
  - one saturating read-modify-write update port.
- The top level contains the misprediction logic, the next-PC mux and the optional statistics.

## Test plan
- Reset, then branch_id_i=1, pc_id_i=0x40, jmp_id_i=0x80 → predict_o=1, next_pc_o=0x80 (weakly taken).
- EX branch at 0x40 with predict_ex_i=1, taken_ex_i=0, jmp_ex_i=0x80 → same cycle: flush_o=1, next_pc_o=0x44. After the edge, the counter at idx 0x0 is 01 and a new ID branch at 0x40 gives predict_o=0.
- Three taken resolutions at 0x10 followed by a fourth → counter saturates at 11. One not-taken resolution → 10, prediction is still taken.
- Same cycle: mispredict in EX (recovery 0x200) and predicted-taken branch in ID (target 0x300) → next_pc_o=0x200.
- Same cycle: ID read and EX update of index 5 (pc 0x14 and 0x54, counter at 01), taken_ex_i=1, predict_ex_i=1 → predict_o=0, flush_o=0. Next cycle, a read of 0x14 gives predict_o=1.
- BHT_STATS_EN defined: 10 EX branches of which 3 mispredict → stat_branches_o=10, stat_mispredicts_o=3. Asserting rst_n_i mid-run clears both counters immediately.
